// File: rtl/goomba_contact_arbiter.sv
// Per-frame Mario/Goomba contact arbiter: emits toggle events for wall turn, stomp and player hit.
// Optional feature: define STOMP_BOUNCE_EN to add the mario_bounce pulse output.
module goomba_contact_arbiter #(
    parameter int COORD_W         = 11,
    parameter int STOMP_MARGIN    = 8,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] mario_x,
    input  logic [COORD_W-1:0] mario_y,
    input  logic [COORD_W-1:0] mario_w,
    input  logic [COORD_W-1:0] mario_h,
    input  logic               mario_falling,
    input  logic [COORD_W-1:0] goomba_x,
    input  logic [COORD_W-1:0] goomba_y,
    input  logic [COORD_W-1:0] goomba_w,
    input  logic [COORD_W-1:0] goomba_h,
    input  logic               goomba_live,
    input  logic               goomba_oriental,
    input  logic               wall_left,
    input  logic               wall_right,
    output logic               collapsion_impulse,
    output logic               press_impulse,
    output logic               mario_hit_impulse,
    output logic               busy
`ifdef STOMP_BOUNCE_EN
    ,
    output logic               mario_bounce
`endif
);

    localparam int SUM_W = COORD_W + 1;
    localparam logic [COORD_W-1:0] MARGIN   = COORD_W'(STOMP_MARGIN);
    localparam logic [7:0]         CD_LOAD  = 8'(COOLDOWN_FRAMES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_EVAL     = 3'd2;
    localparam logic [2:0] S_EMIT     = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    // Sums carry one extra bit so boxes near the right/bottom screen edge never wrap.
    function automatic logic [SUM_W-1:0] ext_sum(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic span_overlap(input logic [COORD_W-1:0] a_pos,
                                          input logic [COORD_W-1:0] a_len,
                                          input logic [COORD_W-1:0] b_pos,
                                          input logic [COORD_W-1:0] b_len);
        return (a_len != '0) && (b_len != '0) &&
               ({1'b0, a_pos} < ext_sum(b_pos, b_len)) &&
               ({1'b0, b_pos} < ext_sum(a_pos, a_len));
    endfunction

    function automatic logic shallow_enough(input logic [COORD_W-1:0] m_y,
                                            input logic [COORD_W-1:0] m_h,
                                            input logic [COORD_W-1:0] g_y);
        return ext_sum(m_y, m_h) <= ext_sum(g_y, MARGIN);
    endfunction

    logic [2:0] state;
    logic [7:0] cd_cnt;
    logic       accept;
    logic       blocked_q;

    logic [COORD_W-1:0] mx_p0, my_p0, mw_p0, mh_p0;
    logic [COORD_W-1:0] gx_p0, gy_p0, gw_p0, gh_p0;
    logic               fall_p0, live_p0, orient_p0, wl_p0, wr_p0, body_en_p0;
    logic               vld_p0;

    logic               overlap_p1, stomp_p1, blk_p1, body_en_p1;
    logic               vld_p1;

    logic               press_p2, hit_p2, turn_p2;
    logic               vld_p2;

    // Body contacts are only evaluated for frames accepted from IDLE; cooldown frames run wall-only.
    assign accept = frame_tick && ((state == S_IDLE) || (state == S_COOLDOWN));
    assign busy   = (state != S_IDLE);

    // Stage p0: snapshot of all inputs on an accepted frame_tick
    always_ff @(posedge clk) begin
        if (accept) begin
            mx_p0      <= mario_x;
            my_p0      <= mario_y;
            mw_p0      <= mario_w;
            mh_p0      <= mario_h;
            fall_p0    <= mario_falling;
            gx_p0      <= goomba_x;
            gy_p0      <= goomba_y;
            gw_p0      <= goomba_w;
            gh_p0      <= goomba_h;
            live_p0    <= goomba_live;
            orient_p0  <= goomba_oriental;
            wl_p0      <= wall_left;
            wr_p0      <= wall_right;
            body_en_p0 <= (state == S_IDLE);
        end
    end

    // Stage p1: geometry terms from the latched copy
    always_ff @(posedge clk) begin
        overlap_p1 <= live_p0 &&
                      span_overlap(mx_p0, mw_p0, gx_p0, gw_p0) &&
                      span_overlap(my_p0, mh_p0, gy_p0, gh_p0);
        stomp_p1   <= live_p0 && fall_p0 &&
                      span_overlap(mx_p0, mw_p0, gx_p0, gw_p0) &&
                      span_overlap(my_p0, mh_p0, gy_p0, gh_p0) &&
                      shallow_enough(my_p0, mh_p0, gy_p0);
        blk_p1     <= orient_p0 ? wl_p0 : wr_p0;
        body_en_p1 <= body_en_p0;
    end

    // Stage p2: event resolution; stomp wins over hit, wall turn is edge-detected
    always_ff @(posedge clk) begin
        press_p2 <= body_en_p1 && stomp_p1;
        hit_p2   <= body_en_p1 && overlap_p1 && !stomp_p1;
        turn_p2  <= blk_p1 && !blocked_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1)
                blocked_q <= blk_p1;
        end
    end

    // Output stage: toggles applied in the EMIT cycle of each evaluated frame
    always_ff @(posedge clk) begin
        if (!rstn) begin
            collapsion_impulse <= 1'b0;
            press_impulse      <= 1'b0;
            mario_hit_impulse  <= 1'b0;
        end else if (vld_p2) begin
            collapsion_impulse <= collapsion_impulse ^ turn_p2;
            press_impulse      <= press_impulse ^ press_p2;
            mario_hit_impulse  <= mario_hit_impulse ^ hit_p2;
        end
    end

`ifdef STOMP_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            mario_bounce <= 1'b0;
        else
            mario_bounce <= vld_p2 && press_p2;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_IDLE;
            cd_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_tick)
                        state <= S_LATCH;
                end
                S_LATCH: state <= S_EVAL;
                S_EVAL:  state <= S_EMIT;
                S_EMIT: begin
                    if (press_p2 || hit_p2) begin
                        state  <= S_COOLDOWN;
                        cd_cnt <= CD_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_COOLDOWN: begin
                    // Leave on the tick that brings the counter to zero.
                    if (cd_cnt == 8'd0) begin
                        state <= S_IDLE;
                    end else if (frame_tick) begin
                        cd_cnt <= cd_cnt - 8'd1;
                        if (cd_cnt == 8'd1)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goomba_contact_arbiter.sv
// Self-checking bench for goomba_contact_arbiter: directed vector table, corner sequences, random frames vs a frame-level model.
module tb_goomba_contact_arbiter;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rstn;
    logic         frame_tick;
    logic [W-1:0] mario_x, mario_y, mario_w, mario_h;
    logic         mario_falling;
    logic [W-1:0] goomba_x, goomba_y, goomba_w, goomba_h;
    logic         goomba_live, goomba_oriental, wall_left, wall_right;
    logic         collapsion_impulse, press_impulse, mario_hit_impulse, busy;
`ifdef STOMP_BOUNCE_EN
    logic         mario_bounce;
`endif

    always #5 clk = ~clk;

    goomba_contact_arbiter dut (
        .clk                (clk),
        .rstn               (rstn),
        .frame_tick         (frame_tick),
        .mario_x            (mario_x),
        .mario_y            (mario_y),
        .mario_w            (mario_w),
        .mario_h            (mario_h),
        .mario_falling      (mario_falling),
        .goomba_x           (goomba_x),
        .goomba_y           (goomba_y),
        .goomba_w           (goomba_w),
        .goomba_h           (goomba_h),
        .goomba_live        (goomba_live),
        .goomba_oriental    (goomba_oriental),
        .wall_left          (wall_left),
        .wall_right         (wall_right),
        .collapsion_impulse (collapsion_impulse),
        .press_impulse      (press_impulse),
        .mario_hit_impulse  (mario_hit_impulse),
        .busy               (busy)
`ifdef STOMP_BOUNCE_EN
        ,
        .mario_bounce       (mario_bounce)
`endif
    );

    typedef struct {
        logic [W-1:0] mx, my, mw, mh;
        logic         fall;
        logic [W-1:0] gx, gy, gw, gh;
        logic         live, orient, wl, wr;
        logic         e_press, e_hit, e_wall;
    } vec_t;

    vec_t vecs[12];

    int checks = 0;
    int errors = 0;

    // Frame-level reference state
    int m_press, m_hit, m_wall, m_cd, m_blk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_press = 0; m_hit = 0; m_wall = 0; m_cd = 0; m_blk = 0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic set_boxes(input int mx, input int my, input int mw, input int mh, input bit fall,
                             input int gx, input int gy, input int gw, input int gh);
        mario_x = W'(mx); mario_y = W'(my); mario_w = W'(mw); mario_h = W'(mh);
        mario_falling = fall;
        goomba_x = W'(gx); goomba_y = W'(gy); goomba_w = W'(gw); goomba_h = W'(gh);
    endtask

    task automatic apply_vec(input vec_t v);
        mario_x = v.mx; mario_y = v.my; mario_w = v.mw; mario_h = v.mh; mario_falling = v.fall;
        goomba_x = v.gx; goomba_y = v.gy; goomba_w = v.gw; goomba_h = v.gh;
        goomba_live = v.live; goomba_oriental = v.orient; wall_left = v.wl; wall_right = v.wr;
    endtask

    // Whole-frame rules applied to the present input values
    task automatic model_frame();
        int  mx, my, mw, mh, gx, gy, gw, gh;
        bit  ov, st, ht, blk;
        mx = int'(mario_x); my = int'(mario_y); mw = int'(mario_w); mh = int'(mario_h);
        gx = int'(goomba_x); gy = int'(goomba_y); gw = int'(goomba_w); gh = int'(goomba_h);
        ov  = (mw > 0) && (mh > 0) && (gw > 0) && (gh > 0) &&
              (mx < gx + gw) && (gx < mx + mw) && (my < gy + gh) && (gy < my + mh);
        st  = goomba_live && ov && mario_falling && (my + mh <= gy + 8);
        ht  = goomba_live && ov && !st;
        blk = goomba_oriental ? wall_left : wall_right;
        if (blk && (m_blk == 0)) m_wall ^= 1;
        m_blk = blk;
        if (m_cd > 0) begin
            m_cd--;
        end else begin
            if (st) m_press ^= 1;
            if (ht) m_hit ^= 1;
            if (st || ht) m_cd = 8;
        end
    endtask

    initial begin
        rstn = 1'b0;
        frame_tick = 1'b0;
        set_boxes(0, 0, 0, 0, 0, 0, 0, 0, 0);
        goomba_live = 1'b0; goomba_oriental = 1'b0; wall_left = 1'b0; wall_right = 1'b0;

        //          mx    my    mw  mh  fall gx    gy    gw  gh  live or wl wr  press hit wall
        vecs[0]  = '{100,  200,  16, 16, 1, 100,  212,  16, 16, 1, 0, 0, 0, 1, 0, 0}; // stomp
        vecs[1]  = '{90,   212,  16, 16, 0, 100,  212,  16, 16, 1, 0, 0, 0, 0, 1, 0}; // side hit
        vecs[2]  = '{84,   212,  16, 16, 0, 100,  212,  16, 16, 1, 0, 0, 0, 0, 0, 0}; // edge touch
        vecs[3]  = '{100,  204,  16, 16, 1, 100,  212,  16, 16, 1, 0, 0, 0, 1, 0, 0}; // depth == margin
        vecs[4]  = '{100,  205,  16, 16, 1, 100,  212,  16, 16, 1, 0, 0, 0, 0, 1, 0}; // depth margin+1
        vecs[5]  = '{100,  196,  16, 16, 1, 100,  212,  16, 16, 1, 0, 0, 0, 0, 0, 0}; // bottom touches top
        vecs[6]  = '{95,   212,  16, 16, 0, 100,  212,  0,  16, 1, 0, 0, 0, 0, 0, 0}; // zero width
        vecs[7]  = '{100,  212,  16, 16, 1, 100,  212,  16, 16, 0, 1, 1, 0, 0, 0, 1}; // dead + wall
        vecs[8]  = '{2040, 2040, 15, 15, 0, 2047, 2047, 1,  1,  1, 0, 0, 0, 0, 1, 0}; // no wrap
        vecs[9]  = '{300,  100,  16, 16, 0, 100,  212,  16, 16, 1, 0, 0, 1, 0, 0, 1}; // wall ahead right
        vecs[10] = '{300,  100,  16, 16, 0, 100,  212,  16, 16, 1, 0, 1, 0, 0, 0, 0}; // wall behind
        vecs[11] = '{100,  200,  16, 16, 1, 100,  212,  16, 16, 1, 0, 0, 1, 1, 0, 1}; // stomp + wall

        for (int i = 0; i < 12; i++) begin
            do_reset();
            apply_vec(vecs[i]);
            pulse_tick();
            settle();
            chk($sformatf("vec%0d_press", i), int'(press_impulse), int'(vecs[i].e_press));
            chk($sformatf("vec%0d_hit", i), int'(mario_hit_impulse), int'(vecs[i].e_hit));
            chk($sformatf("vec%0d_wall", i), int'(collapsion_impulse), int'(vecs[i].e_wall));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_press | vecs[i].e_hit));
        end

        // Stomp: reset state, exact latency, cooldown length
        do_reset();
        chk("rst_press", int'(press_impulse), 0);
        chk("rst_hit", int'(mario_hit_impulse), 0);
        chk("rst_wall", int'(collapsion_impulse), 0);
        chk("rst_busy", int'(busy), 0);
        goomba_live = 1'b1; goomba_oriental = 1'b0; wall_left = 1'b0; wall_right = 1'b0;
        set_boxes(100, 200, 16, 16, 1, 100, 212, 16, 16);
        pulse_tick();
        @(negedge clk);
        @(negedge clk);
        chk("stomp_t3_press", int'(press_impulse), 0);
        @(negedge clk);
        chk("stomp_t4_press", int'(press_impulse), 1);
        chk("stomp_t4_hit", int'(mario_hit_impulse), 0);
`ifdef STOMP_BOUNCE_EN
        chk("stomp_bounce_on", int'(mario_bounce), 1);
        @(negedge clk);
        chk("stomp_bounce_off", int'(mario_bounce), 0);
`endif
        for (int k = 1; k <= 7; k++) begin
            pulse_tick();
            settle();
            chk($sformatf("cool_busy_%0d", k), int'(busy), 1);
        end
        pulse_tick();
        settle();
        chk("cool_end_busy", int'(busy), 0);
        chk("cool_end_press", int'(press_impulse), 1);

        // Side hit, then a tick inside the cooldown
        do_reset();
        set_boxes(90, 212, 16, 16, 0, 100, 212, 16, 16);
        pulse_tick();
        settle();
        chk("side_hit", int'(mario_hit_impulse), 1);
        chk("side_press", int'(press_impulse), 0);
        pulse_tick();
        settle();
        chk("side_cool_hit", int'(mario_hit_impulse), 1);
        chk("side_cool_busy", int'(busy), 1);

        // Reset during cooldown clears everything on the next edge
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstcool_hit", int'(mario_hit_impulse), 0);
        chk("rstcool_busy", int'(busy), 0);
        chk("rstcool_press", int'(press_impulse), 0);
        chk("rstcool_wall", int'(collapsion_impulse), 0);
        rstn = 1'b1;

        // Wall held for five frames turns once; release and reassert turns again
        do_reset();
        set_boxes(300, 100, 16, 16, 0, 100, 212, 16, 16);
        goomba_oriental = 1'b1; wall_left = 1'b1; wall_right = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            settle();
            chk($sformatf("wall_hold_%0d", k), int'(collapsion_impulse), 1);
        end
        wall_left = 1'b0;
        pulse_tick();
        settle();
        chk("wall_release", int'(collapsion_impulse), 1);
        wall_left = 1'b1;
        pulse_tick();
        settle();
        chk("wall_reassert", int'(collapsion_impulse), 0);

        // Dead goomba: no body events, wall edge still counts
        do_reset();
        set_boxes(100, 212, 16, 16, 1, 100, 212, 16, 16);
        goomba_live = 1'b0; goomba_oriental = 1'b0; wall_left = 1'b0; wall_right = 1'b0;
        pulse_tick();
        settle();
        chk("dead_press", int'(press_impulse), 0);
        chk("dead_hit", int'(mario_hit_impulse), 0);
        chk("dead_busy", int'(busy), 0);
        wall_right = 1'b1;
        pulse_tick();
        settle();
        chk("dead_wall", int'(collapsion_impulse), 1);
        chk("dead_hit2", int'(mario_hit_impulse), 0);

        // Wall turn during cooldown alongside a stomp frame
        do_reset();
        goomba_live = 1'b1; goomba_oriental = 1'b0; wall_left = 1'b0; wall_right = 1'b0;
        set_boxes(100, 200, 16, 16, 1, 100, 212, 16, 16);
        pulse_tick();
        settle();
        wall_right = 1'b1;
        pulse_tick();
        settle();
        chk("coolwall_wall", int'(collapsion_impulse), 1);
        chk("coolwall_press", int'(press_impulse), 1);

        // Ticks held through LATCH and EVAL are dropped
        do_reset();
        goomba_live = 1'b1; wall_right = 1'b0;
        set_boxes(90, 212, 16, 16, 0, 100, 212, 16, 16);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        frame_tick = 1'b0;
        settle();
        chk("drop_hit", int'(mario_hit_impulse), 1);
        chk("drop_busy", int'(busy), 1);

        // Random frames against the frame-level model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int off;
            off = ($urandom_range(0, 7) == 0) ? 1970 : 0;
            goomba_x = W'(off + $urandom_range(20, 60));
            goomba_y = W'(off + $urandom_range(20, 60));
            goomba_w = W'($urandom_range(0, 12));
            goomba_h = W'($urandom_range(0, 12));
            mario_w  = W'($urandom_range(0, 12));
            mario_h  = W'($urandom_range(0, 12));
            mario_x  = W'(int'(goomba_x) - 12 + $urandom_range(0, 24));
            if ($urandom_range(0, 1) == 1)
                mario_y = W'(int'(goomba_y) - int'(mario_h) + $urandom_range(0, 12));
            else
                mario_y = W'(int'(goomba_y) - 12 + $urandom_range(0, 24));
            mario_falling   = 1'($urandom_range(0, 1));
            goomba_live     = ($urandom_range(0, 4) != 0);
            goomba_oriental = 1'($urandom_range(0, 1));
            wall_left       = 1'($urandom_range(0, 1));
            wall_right      = 1'($urandom_range(0, 1));
            model_frame();
            pulse_tick();
            settle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk($sformatf("rnd%0d_press", n), int'(press_impulse), m_press);
            chk($sformatf("rnd%0d_hit", n), int'(mario_hit_impulse), m_hit);
            chk($sformatf("rnd%0d_wall", n), int'(collapsion_impulse), m_wall);
            chk($sformatf("rnd%0d_busy", n), int'(busy), (m_cd > 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
